// File: rtl/cargador_instrucciones_pkg.sv
// Shared types and constants for the UART-to-instruction-memory loader:
// FSM encoding, HALT opcode, opcode field bounds and bytes-per-word helper.
package cargador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  function automatic int bytes_per_word(input int len, input int len_data);
    return len / len_data;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(32, 8);

endpackage

// File: rtl/cargador_instrucciones_empaquetador.sv
// Byte packer: shifts bytes in MSB-first and flags word_valid on the byte
// that completes a word; the counter then restarts at zero on its own.
module empaquetador_bytes
  import cargador_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int LEN_DATA = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                byte_vld,
  input  logic [LEN_DATA-1:0] byte_in,
  output logic [LEN-1:0]      word_out,
  output logic                word_valid,
  output logic                byte_pending
);

  localparam int BPW   = bytes_per_word(LEN, LEN_DATA);
  localparam int CNT_W = $clog2(BPW + 1);

  logic [LEN-1:0]   shift_q, shift_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shifted    = {shift_q[LEN-LEN_DATA-1:0], byte_in};
    word_out   = shifted;
    word_valid = byte_vld && !clr && (cnt_q == CNT_W'(BPW - 1));
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_vld) begin
      shift_d = shifted;
      cnt_d   = word_valid ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign byte_pending = (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cargador_instrucciones.sv
// Loads 32-bit instructions received byte-by-byte over UART into instruction
// memory. Optional inter-byte timeout enabled by defining CARGADOR_TIMEOUT_EN.
module cargador_instrucciones
  import cargador_pkg::*;
#(
  parameter int         LEN                = 32,
  parameter int         LEN_DATA           = 8,
  parameter int         cant_instrucciones = 64,
  parameter logic [5:0] HALT_OPCODE        = cargador_pkg::HALT_OPCODE_DEF
`ifdef CARGADOR_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES     = 2_000_000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                rx_done,
  input  logic [LEN_DATA-1:0] uart_data_in,
  output logic [LEN-1:0]      addr_mem_inst,
  output logic [LEN-1:0]      ins_to_mem,
  output logic                wea,
  output logic                busy,
  output logic                done,
`ifdef CARGADOR_TIMEOUT_EN
  output logic                timeout,
`endif
  output logic                full
);

  localparam logic [LEN-1:0] LAST_ADDR = LEN'(cant_instrucciones - 1);

  state_t         state_q, state_d;
  logic [LEN-1:0] addr_q, addr_d;
  logic [LEN-1:0] ins_q, ins_d;
  logic           full_q, full_d;

  logic           pk_vld, pk_clr, pk_valid, pk_pending;
  logic [LEN-1:0] pk_word;

`ifdef CARGADOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
  logic             tmo_run, tmo_hit;

  // Gap counter only runs while a partial word is waiting for its next byte.
  always_comb begin
    tmo_run = (state_q == ST_RECV) && pk_pending && !rx_done;
    tmo_hit = tmo_run && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    tmo_d   = tmo_run ? tmo_q + TMO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_pending;
  assign unused_pending = pk_pending;
`endif

  // A byte arriving during WRITE already belongs to the next word.
  always_comb begin
    pk_vld = rx_done && ((state_q == ST_RECV) || (state_q == ST_WRITE));
    pk_clr = (state_q == ST_IDLE) && start;
`ifdef CARGADOR_TIMEOUT_EN
    pk_clr = pk_clr || tmo_hit;
`endif
  end

  empaquetador_bytes #(
    .LEN      (LEN),
    .LEN_DATA (LEN_DATA)
  ) u_empaquetador (
    .clk          (clk),
    .reset        (reset),
    .clr          (pk_clr),
    .byte_vld     (pk_vld),
    .byte_in      (uart_data_in),
    .word_out     (pk_word),
    .word_valid   (pk_valid),
    .byte_pending (pk_pending)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ins_d   = ins_q;
    full_d  = full_q;
`ifdef CARGADOR_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RECV;
          addr_d  = '0;
          full_d  = 1'b0;
`ifdef CARGADOR_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      ST_RECV: begin
        if (pk_valid) begin
          ins_d   = pk_word;
          state_d = ST_WRITE;
        end
`ifdef CARGADOR_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
`endif
      end
      ST_WRITE: begin
        if (ins_q[OPC_HI:OPC_LO] == HALT_OPCODE) begin
          state_d = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          full_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + LEN'(1);
          state_d = ST_RECV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      ins_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ins_q   <= ins_d;
      full_q  <= full_d;
    end
  end

  assign addr_mem_inst = addr_q;
  assign ins_to_mem    = ins_q;
  assign wea           = (state_q == ST_WRITE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign full          = full_q;

endmodule
